// File: rtl/tl45_io_pkg.sv
// Shared constants for the TL45 board I/O path (switch width, debounce defaults).
package tl45_io_pkg;
  localparam int SW_NBITS              = 16;
  localparam int DEBOUNCE_TICK_DIV     = 100000;
  localparam int DEBOUNCE_STABLE_TICKS = 8;
endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: counts consecutive sample ticks on which the synchronised
// input disagrees with the held state, and flips the state once enough have been seen.
module debounce_bit
  import tl45_io_pkg::*;
#(
  parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick,
  input  logic i_sync,
  output logic o_state,
  output logic o_changed
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          state_next;
  logic          changed_next;

  // Next-state: agreement zeroes the count, so any bounce restarts qualification.
  always_comb begin
    count_next   = count;
    state_next   = o_state;
    changed_next = 1'b0;
    if (i_tick) begin
      if (i_sync == o_state) begin
        count_next = '0;
      end else if (count == LAST_COUNT) begin
        count_next   = '0;
        state_next   = i_sync;
        changed_next = 1'b1;
      end else begin
        count_next = count + CW'(1);
      end
    end else begin
      count_next = count;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count     <= '0;
      o_state   <= 1'b0;
      o_changed <= 1'b0;
    end else begin
      count     <= count_next;
      o_state   <= state_next;
      o_changed <= changed_next;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw slide switches: two-flop synchroniser, shared sample-tick
// prescaler, and one stability counter per bit.
module switch_debouncer
  import tl45_io_pkg::*;
#(
  parameter int NBITS        = SW_NBITS,
  parameter int TICK_DIV     = DEBOUNCE_TICK_DIV,
  parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NBITS-1:0] i_switches,
  output logic [NBITS-1:0] o_switches,
  output logic [NBITS-1:0] o_changed,
  output logic             o_any_changed,
  output logic             o_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [NBITS-1:0] stage1;
  logic [NBITS-1:0] sync;
  logic [PW-1:0]    pre_count;
  logic             tick;

  assign tick = (pre_count == PRE_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stage1 <= '0;
      sync   <= '0;
    end else begin
      stage1 <= i_switches;
      sync   <= stage1;
    end
  end

  // With TICK_DIV == 1 the count stays at 0 and tick is permanently high.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_count <= '0;
      o_tick    <= 1'b0;
    end else begin
      o_tick <= tick;
      if (tick) begin
        pre_count <= '0;
      end else begin
        pre_count <= pre_count + PW'(1);
      end
    end
  end

  for (genvar k = 0; k < NBITS; k++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .i_tick   (tick),
      .i_sync   (sync[k]),
      .o_state  (o_switches[k]),
      .o_changed(o_changed[k])
    );
  end

  // Reduction of flop outputs only, so it lines up with o_changed in the same cycle.
  assign o_any_changed = |o_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench: a tick-sample window model checks two debouncer configurations every cycle,
// plus directed latency, bounce, glitch, simultaneous and reset scenarios.
module tb_switch_debouncer;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [15:0] sw_a, sw_b;
  logic [15:0] osw_a, och_a, osw_b, och_b;
  logic        oany_a, otick_a, oany_b, otick_b;

  int checks = 0;
  int errors = 0;
  int lat, pulses, anyc, bad, base;

  always #5 clk = ~clk;

  switch_debouncer #(.NBITS(16), .TICK_DIV(4), .STABLE_TICKS(3)) dut_a (
    .i_clk(clk), .i_reset_n(rst_a), .i_switches(sw_a), .o_switches(osw_a),
    .o_changed(och_a), .o_any_changed(oany_a), .o_tick(otick_a));

  switch_debouncer #(.NBITS(16), .TICK_DIV(1), .STABLE_TICKS(1)) dut_b (
    .i_clk(clk), .i_reset_n(rst_b), .i_switches(sw_b), .o_switches(osw_b),
    .o_changed(och_b), .o_any_changed(oany_b), .o_tick(otick_b));

  // Model: index 0 = (TICK_DIV 4, STABLE 3), index 1 = (TICK_DIV 1, STABLE 1).
  localparam int SZ = 16384;
  logic [15:0] m_d1[2], m_d2[2], m_out[2], m_chg[2];
  logic        m_tick[2];
  int          m_edge[2], m_nt[2];
  int          m_last[2][16];
  logic [15:0] m_samp[2][SZ];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic model_reset(input int d);
    m_d1[d] = 16'h0000; m_d2[d] = 16'h0000; m_out[d] = 16'h0000; m_chg[d] = 16'h0000;
    m_tick[d] = 1'b0; m_edge[d] = 0; m_nt[d] = 0;
    for (int k = 0; k < 16; k++) m_last[d][k] = 0;
  endtask

  // An output bit flips when the last STABLE tick samples, all taken after its
  // previous flip, every one disagree with it.
  task automatic model_step(input int d, input logic [15:0] din);
    int td, st, t;
    logic [15:0] sn;
    bit ok;
    td = (d == 0) ? 4 : 1;
    st = (d == 0) ? 3 : 1;
    sn = m_d2[d];
    m_d2[d] = m_d1[d];
    m_d1[d] = din;
    m_edge[d] = m_edge[d] + 1;
    m_chg[d] = 16'h0000;
    m_tick[d] = ((m_edge[d] % td) == 0);
    if (m_tick[d]) begin
      m_nt[d] = m_nt[d] + 1;
      t = m_nt[d];
      m_samp[d][t % SZ] = sn;
      for (int k = 0; k < 16; k++) begin
        ok = (t >= st);
        for (int j = 0; j < st; j++) begin
          if (ok && ((t - j) <= m_last[d][k] || m_samp[d][(t - j) % SZ][k] == m_out[d][k]))
            ok = 0;
        end
        if (ok) begin
          m_out[d][k] = sn[k];
          m_chg[d][k] = 1'b1;
          m_last[d][k] = t;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_a) model_reset(0); else model_step(0, sw_a);
      if (!rst_b) model_reset(1); else model_step(1, sw_b);
      #1;
      chk("a_sw",   osw_a, m_out[0]);
      chk("a_chg",  och_a, m_chg[0]);
      chk("a_any",  {15'b0, oany_a},  {15'b0, |m_chg[0]});
      chk("a_tick", {15'b0, otick_a}, {15'b0, m_tick[0]});
      chk("b_sw",   osw_b, m_out[1]);
      chk("b_chg",  och_b, m_chg[1]);
      chk("b_any",  {15'b0, oany_b},  {15'b0, |m_chg[1]});
      chk("b_tick", {15'b0, otick_b}, {15'b0, m_tick[1]});
    end
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; sw_a = 16'hFFFF; sw_b = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_sw", osw_a, 16'h0000);
    chk("rst_chg", och_a, 16'h0000);
    rst_a = 1'b1; rst_b = 1'b1; sw_a = 16'h0000;
    repeat (3) @(posedge clk);
    #1 chk("tick_early", {15'b0, otick_a}, 16'h0000);
    @(posedge clk);
    #1 chk("tick_first", {15'b0, otick_a}, 16'h0001);

    // Clean step on bit 0
    @(negedge clk); sw_a = 16'h0001;
    lat = 0; pulses = 0; anyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (osw_a[0] && lat == 0) lat = i;
      if (och_a != 16'h0000) pulses++;
      if (och_a == 16'h0001 && oany_a) anyc++;
    end
    chk_rng("step_lat", lat, 11, 14);
    chk_rng("step_pulses", pulses, 1, 1);
    chk_rng("step_any", anyc, 1, 1);

    // Bounce on bit 3: 1,0,1 with one-tick spacing, then hold
    @(negedge clk); sw_a = 16'h0009;
    repeat (4) @(negedge clk); sw_a = 16'h0001;
    repeat (4) @(negedge clk); sw_a = 16'h0009;
    lat = 0; pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (osw_a[3] && lat == 0) lat = i;
      if (och_a[3]) pulses++;
    end
    chk_rng("bounce_lat", lat, 11, 14);
    chk_rng("bounce_pulses", pulses, 1, 1);
    chk("bounce_final", osw_a, 16'h0009);

    // Glitch on bit 7 lasting two ticks
    @(negedge clk); sw_a = 16'h0089;
    repeat (8) @(negedge clk); sw_a = 16'h0009;
    bad = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (osw_a != 16'h0009 || och_a != 16'h0000) bad++;
    end
    chk_rng("glitch_bad", bad, 0, 0);

    @(negedge clk); sw_a = 16'h0000;
    repeat (20) @(negedge clk);
    chk("settle0", osw_a, 16'h0000);

    // Simultaneous rise then fall
    @(negedge clk); sw_a = 16'hA5A5;
    lat = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (och_a != 16'h0000) pulses++;
      if (osw_a != 16'h0000 && lat == 0) begin
        lat = i;
        chk("simul_rise_sw", osw_a, 16'hA5A5);
        chk("simul_rise_chg", och_a, 16'hA5A5);
        chk("simul_rise_any", {15'b0, oany_a}, 16'h0001);
      end
    end
    chk_rng("simul_rise_lat", lat, 11, 14);
    chk_rng("simul_rise_pulses", pulses, 1, 1);

    @(negedge clk); sw_a = 16'h0000;
    lat = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (och_a != 16'h0000) pulses++;
      if (osw_a != 16'hA5A5 && lat == 0) begin
        lat = i;
        chk("simul_fall_sw", osw_a, 16'h0000);
        chk("simul_fall_chg", och_a, 16'hA5A5);
      end
    end
    chk_rng("simul_fall_lat", lat, 11, 14);
    chk_rng("simul_fall_pulses", pulses, 1, 1);

    // Reset while bit 0 has counted two disagreeing ticks
    @(negedge clk); sw_a = 16'h0001;
    repeat (2) @(negedge clk);
    base = m_nt[0];
    for (int i = 0; i < 20 && m_nt[0] < base + 2; i++) @(negedge clk);
    chk_rng("mid_wait", m_nt[0] - base, 2, 2);
    rst_a = 1'b0;
    #1;
    chk("mid_rst_sw", osw_a, 16'h0000);
    chk("mid_rst_tick", {15'b0, otick_a}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (11) @(posedge clk);
    #1 chk("mid_e11", osw_a, 16'h0000);
    @(posedge clk);
    #1 chk("mid_e12", osw_a, 16'h0001);

    // Tick every cycle, accept on first tick: three edges input-to-output
    @(negedge clk); sw_b = 16'h1234;
    repeat (2) @(posedge clk);
    #1 chk("b1_e2", osw_b, 16'h0000);
    @(posedge clk);
    #1 chk("b1_e3", osw_b, 16'h1234);
    chk("b1_chg", och_b, 16'h1234);
    @(negedge clk); sw_b = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1 chk("b2_e2", osw_b, 16'h1234);
    @(posedge clk);
    #1 chk("b2_e3", osw_b, 16'hFFFF);
    chk("b2_chg", och_b, 16'hEDCB);
    @(negedge clk); sw_b = 16'h0000;
    repeat (2) @(posedge clk);
    #1 chk("b3_e2", osw_b, 16'hFFFF);
    @(posedge clk);
    #1 chk("b3_e3", osw_b, 16'h0000);
    chk("b3_chg", och_b, 16'hFFFF);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
